// File: rtl/tlc_pkg.sv
// Shared types and constants for the traffic-light controller slice.
// Holds the FSM state encoding, the per-road phase indices and the default phase delays.
package tlc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_WAIT  = 2'd2,
    ST_FAULT = 2'd3
  } tlc_state_e;

  localparam int PH_RED_IN    = 0;
  localparam int PH_AMBER_IN  = 1;
  localparam int PH_GREEN     = 2;
  localparam int PH_AMBER_OUT = 3;
  localparam int PH_RED_OUT   = 4;
  localparam int NUM_PHASES   = 5;

  localparam int T0_DEF        = 2;
  localparam int T1_DEF        = 3;
  localparam int T2_DEF        = 10;
  localparam int T3_DEF        = 3;
  localparam int T4_DEF        = 2;
  localparam int COUNT_MAX_DEF = 15;

  function automatic logic delay_fits(input int t, input int count_max);
    return (t >= 0) && (t <= count_max);
  endfunction

endpackage

// File: rtl/tlc_timing_rom.sv
// Phase-index to delay lookup for one road's light sequence.
// Purely combinational; any index outside the phase table yields zero.
module tlc_timing_rom
  import tlc_pkg::*;
#(
  parameter int IDX_W = 3,
  parameter int CNT_W = 4,
  parameter int T0    = T0_DEF,
  parameter int T1    = T1_DEF,
  parameter int T2    = T2_DEF,
  parameter int T3    = T3_DEF,
  parameter int T4    = T4_DEF
) (
  input  logic [IDX_W-1:0] index_i,
  output logic [CNT_W-1:0] delay_o
);

  always_comb begin
    delay_o = '0;
    case (32'(index_i))
      PH_RED_IN:    delay_o = CNT_W'(T0);
      PH_AMBER_IN:  delay_o = CNT_W'(T1);
      PH_GREEN:     delay_o = CNT_W'(T2);
      PH_AMBER_OUT: delay_o = CNT_W'(T3);
      PH_RED_OUT:   delay_o = CNT_W'(T4);
      default:      delay_o = '0;
    endcase
  end

endmodule

// File: rtl/tlc_control_unit.sv
// Control FSM sequencing the traffic-light datapath through every phase of every road.
// Outputs are decoded from the current state and datapath status; only the state is registered.
//
//   state | meaning
//   IDLE  | datapath held clear, waiting for run
//   LOAD  | delay counter loaded with the current phase delay
//   WAIT  | counting down; advance phase/road or finish the cycle at zero
//   FAULT | illegal index/road seen; held clear until reset
module tlc_control_unit
  import tlc_pkg::*;
#(
  parameter int STATES    = 6,
  parameter int ROADS     = 4,
  parameter int LIGHTS    = NUM_PHASES,
  parameter int COUNT_MAX = COUNT_MAX_DEF,
  parameter int T0        = T0_DEF,
  parameter int T1        = T1_DEF,
  parameter int T2        = T2_DEF,
  parameter int T3        = T3_DEF,
  parameter int T4        = T4_DEF,
  localparam int CNT_W    = $clog2(COUNT_MAX),
  localparam int IDX_W    = $clog2(STATES),
  localparam int ROAD_W   = $clog2(ROADS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run_i,
  input  logic              counter_zero_i,
  input  logic [IDX_W-1:0]  index_i,
  input  logic [ROAD_W-1:0] road_i,
  output logic [CNT_W-1:0]  timing_data_o,
  output logic              load_counter_o,
  output logic              shift_reg_o,
  output logic              inc_index_o,
  output logic              clear_index_o,
  output logic              inc_road_o,
  output logic              clear_o,
  output logic              busy_o,
  output logic              cycle_done_o,
  output logic              fault_o
);

  if (!delay_fits(T0, COUNT_MAX) || !delay_fits(T1, COUNT_MAX) ||
      !delay_fits(T2, COUNT_MAX) || !delay_fits(T3, COUNT_MAX) ||
      !delay_fits(T4, COUNT_MAX)) begin : g_bad_delay
    $error("tlc_control_unit: a phase delay is outside 0..COUNT_MAX");
  end

  if (LIGHTS > STATES || LIGHTS > NUM_PHASES || LIGHTS < 1) begin : g_bad_lights
    $error("tlc_control_unit: LIGHTS must be 1..min(STATES, phase table size)");
  end

  if (ROADS < 2 || STATES < 2 || COUNT_MAX < 2) begin : g_bad_sizes
    $error("tlc_control_unit: ROADS, STATES and COUNT_MAX must each be at least 2");
  end

  tlc_state_e       state_q, state_d;
  logic [CNT_W-1:0] rom_delay;
  logic             idx_bad, road_bad, last_phase, last_road;

  tlc_timing_rom #(
    .IDX_W (IDX_W),
    .CNT_W (CNT_W),
    .T0    (T0),
    .T1    (T1),
    .T2    (T2),
    .T3    (T3),
    .T4    (T4)
  ) u_rom (
    .index_i (index_i),
    .delay_o (rom_delay)
  );

  assign idx_bad    = 32'(index_i) >= LIGHTS;
  assign road_bad   = 32'(road_i) >= ROADS;
  assign last_phase = 32'(index_i) == LIGHTS - 1;
  assign last_road  = 32'(road_i) == ROADS - 1;

  always_comb begin
    state_d        = state_q;
    timing_data_o  = '0;
    load_counter_o = 1'b0;
    shift_reg_o    = 1'b0;
    inc_index_o    = 1'b0;
    clear_index_o  = 1'b0;
    inc_road_o     = 1'b0;
    clear_o        = 1'b0;
    cycle_done_o   = 1'b0;
    fault_o        = 1'b0;
    busy_o         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        clear_o = 1'b1;
        if (run_i) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        busy_o         = 1'b1;
        load_counter_o = 1'b1;
        timing_data_o  = rom_delay;
        state_d        = ST_WAIT;
      end
      ST_WAIT: begin
        busy_o = 1'b1;
        // An out-of-range index or road overrides any countdown decision.
        if (idx_bad || road_bad) begin
          state_d = ST_FAULT;
        end else if (counter_zero_i) begin
          if (!last_phase) begin
            shift_reg_o = 1'b1;
            inc_index_o = 1'b1;
            state_d     = ST_LOAD;
          end else if (!last_road) begin
            shift_reg_o   = 1'b1;
            clear_index_o = 1'b1;
            inc_road_o    = 1'b1;
            state_d       = ST_LOAD;
          end else begin
            clear_o      = 1'b1;
            cycle_done_o = 1'b1;
            state_d      = run_i ? ST_LOAD : ST_IDLE;
          end
        end
      end
      ST_FAULT: begin
        clear_o = 1'b1;
        fault_o = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  a_idx_excl: assert property (@(posedge clk) disable iff (reset)
                               !(inc_index_o && clear_index_o));
  a_cnt_excl: assert property (@(posedge clk) disable iff (reset)
                               !(load_counter_o && shift_reg_o));

endmodule

// File: tb/tb_tlc_control_unit.sv
// Directed bench for tlc_control_unit: default instance plus a zero-length-green instance,
// each driving a small behavioural datapath that closes the counter/index/road loop.
module tb_tlc_control_unit;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic run = 1'b0;
  logic frc = 1'b0;

  always #5 clk = ~clk;

  // instance A: default delays
  logic       a_cz, a_load, a_shift, a_inc_idx, a_clr_idx, a_inc_road, a_clr, a_busy, a_done, a_fault;
  logic [2:0] a_index, a_idx;
  logic [1:0] a_rd;
  logic [3:0] a_td, a_cnt;

  // instance B: green delay of zero
  logic       b_cz, b_load, b_shift, b_inc_idx, b_clr_idx, b_inc_road, b_clr, b_busy, b_done, b_fault;
  logic [2:0] b_idx;
  logic [1:0] b_rd;
  logic [3:0] b_td, b_cnt;

  tlc_control_unit dut_a (
    .clk(clk), .reset(reset), .run_i(run), .counter_zero_i(a_cz), .index_i(a_index), .road_i(a_rd),
    .timing_data_o(a_td), .load_counter_o(a_load), .shift_reg_o(a_shift), .inc_index_o(a_inc_idx),
    .clear_index_o(a_clr_idx), .inc_road_o(a_inc_road), .clear_o(a_clr), .busy_o(a_busy),
    .cycle_done_o(a_done), .fault_o(a_fault)
  );

  tlc_control_unit #(.T2(0)) dut_b (
    .clk(clk), .reset(reset), .run_i(run), .counter_zero_i(b_cz), .index_i(b_idx), .road_i(b_rd),
    .timing_data_o(b_td), .load_counter_o(b_load), .shift_reg_o(b_shift), .inc_index_o(b_inc_idx),
    .clear_index_o(b_clr_idx), .inc_road_o(b_inc_road), .clear_o(b_clr), .busy_o(b_busy),
    .cycle_done_o(b_done), .fault_o(b_fault)
  );

  assign a_cz    = (a_cnt == 4'd0);
  assign a_index = frc ? 3'd6 : a_idx;
  assign b_cz    = (b_cnt == 4'd0);

  always @(posedge clk) begin
    if (reset) begin
      a_cnt <= 4'd0; a_idx <= 3'd0; a_rd <= 2'd0;
    end else begin
      if (a_load) a_cnt <= a_td;
      else if (a_cnt != 4'd0) a_cnt <= a_cnt - 4'd1;
      if (a_clr || a_clr_idx) a_idx <= 3'd0;
      else if (a_inc_idx) a_idx <= a_idx + 3'd1;
      if (a_clr) a_rd <= 2'd0;
      else if (a_inc_road) a_rd <= a_rd + 2'd1;
    end
  end

  always @(posedge clk) begin
    if (reset) begin
      b_cnt <= 4'd0; b_idx <= 3'd0; b_rd <= 2'd0;
    end else begin
      if (b_load) b_cnt <= b_td;
      else if (b_cnt != 4'd0) b_cnt <= b_cnt - 4'd1;
      if (b_clr || b_clr_idx) b_idx <= 3'd0;
      else if (b_inc_idx) b_idx <= b_idx + 3'd1;
      if (b_clr) b_rd <= 2'd0;
      else if (b_inc_road) b_rd <= b_rd + 2'd1;
    end
  end

  int done_cnt = 0;
  int viol_cnt = 0;

  always @(negedge clk) begin
    if (!reset && a_done) done_cnt <= done_cnt + 1;
    if (!reset && ((a_inc_idx && a_clr_idx) || (a_load && a_shift) ||
                   (b_inc_idx && b_clr_idx) || (b_load && b_shift)))
      viol_cnt <= viol_cnt + 1;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int tag, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got %h, expected %h", name, tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // After this returns the DUTs sit in IDLE at "cycle 0", with run still low.
  task automatic do_reset();
    reset = 1'b1; run = 1'b0; frc = 1'b0;
    step(); step();
    reset = 1'b0;
  endtask

  // {load, td[3:0], shift, inc_idx, clr_idx, inc_road, clr, done, busy, fault}
  function automatic logic [15:0] pack_a();
    return {3'b000, a_load, a_td, a_shift, a_inc_idx, a_clr_idx, a_inc_road, a_clr, a_done, a_busy, a_fault};
  endfunction

  typedef struct {
    bit       rst;
    int       cyc;
    bit       run;
    bit       load;
    bit [3:0] td;
    bit       shift;
    bit       inc_idx;
    bit       clr_idx;
    bit       inc_road;
    bit       clr;
    bit       done;
    bit       busy;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int cur;
    int snap;
    logic [15:0] exp_v;

    //          rst cyc run ld td sh ii ci ir cl dn by
    vecs.push_back('{1,   0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0});
    vecs.push_back('{0,   1, 1, 1, 2, 0, 0, 0, 0, 0, 0, 1});
    vecs.push_back('{0,   2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1});
    vecs.push_back('{0,   4, 1, 0, 0, 1, 1, 0, 0, 0, 0, 1});
    vecs.push_back('{0,   5, 1, 1, 3, 0, 0, 0, 0, 0, 0, 1});
    vecs.push_back('{0,  10, 1, 1,10, 0, 0, 0, 0, 0, 0, 1});
    vecs.push_back('{0,  21, 1, 0, 0, 1, 1, 0, 0, 0, 0, 1});
    vecs.push_back('{0,  22, 1, 1, 3, 0, 0, 0, 0, 0, 0, 1});
    vecs.push_back('{0,  27, 1, 1, 2, 0, 0, 0, 0, 0, 0, 1});
    vecs.push_back('{0,  30, 1, 0, 0, 1, 0, 1, 1, 0, 0, 1});
    vecs.push_back('{0,  31, 1, 1, 2, 0, 0, 0, 0, 0, 0, 1});
    vecs.push_back('{0, 119, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1});
    vecs.push_back('{0, 120, 1, 0, 0, 0, 0, 0, 0, 1, 1, 1});
    vecs.push_back('{0, 121, 1, 1, 2, 0, 0, 0, 0, 0, 0, 1});
    // run dropped mid-cycle: the cycle still completes, then IDLE
    vecs.push_back('{1,   0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0});
    vecs.push_back('{0,   1, 1, 1, 2, 0, 0, 0, 0, 0, 0, 1});
    vecs.push_back('{0,  50, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1});
    vecs.push_back('{0,  60, 0, 0, 0, 1, 0, 1, 1, 0, 0, 1});
    vecs.push_back('{0,  61, 0, 1, 2, 0, 0, 0, 0, 0, 0, 1});
    vecs.push_back('{0, 120, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1});
    vecs.push_back('{0, 121, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0});
    vecs.push_back('{0, 125, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0});

    cur = 0;
    snap = 0;
    foreach (vecs[i]) begin
      if (vecs[i].rst) begin
        do_reset();
        cur = 0;
        snap = done_cnt;
      end
      while (cur < vecs[i].cyc) begin
        step();
        cur++;
      end
      run = vecs[i].run;
      exp_v = {3'b000, vecs[i].load, vecs[i].td, vecs[i].shift, vecs[i].inc_idx, vecs[i].clr_idx,
               vecs[i].inc_road, vecs[i].clr, vecs[i].done, vecs[i].busy, 1'b0};
      chk("vec", i, pack_a(), exp_v);
    end
    step();
    chk("cycle_done_count", 0, 16'(done_cnt - snap), 16'd1);

    // zero-length green on instance B: LOAD with 0, then immediate advance
    do_reset();
    run = 1'b1;
    for (int c = 1; c <= 10; c++) step();
    chk("b_green_load", 10, {11'd0, b_load, b_td}, {11'd0, 1'b1, 4'd0});
    step();
    chk("b_green_wait", 11, {13'd0, b_shift, b_inc_idx, b_load}, {13'd0, 3'b110});
    step();
    chk("b_next_load", 12, {11'd0, b_load, b_td}, {11'd0, 1'b1, 4'd3});

    // illegal index during WAIT lands in FAULT and stays there until reset
    do_reset();
    run = 1'b1;
    for (int c = 1; c <= 3; c++) step();
    frc = 1'b1;
    chk("fault_wait", 3, pack_a(), 16'h0002);
    step();
    frc = 1'b0;
    chk("fault_enter", 4, pack_a(), 16'h0009);
    for (int c = 5; c <= 8; c++) begin
      run = ~run;
      step();
      chk("fault_hold", c, pack_a(), 16'h0009);
    end
    reset = 1'b1;
    step();
    chk("fault_reset", 0, pack_a(), 16'h0008);
    reset = 1'b0;
    run = 1'b0;

    // reset mid-WAIT on road 2
    do_reset();
    run = 1'b1;
    for (int c = 1; c <= 75; c++) step();
    chk("road2_wait", 75, pack_a(), 16'h0002);
    reset = 1'b1;
    step();
    chk("road2_reset", 76, pack_a(), 16'h0008);
    step();
    chk("road2_reset_hold", 77, pack_a(), 16'h0008);
    reset = 1'b0;
    run = 1'b0;
    step();

    chk("strobe_exclusion", 0, 16'(viol_cnt), 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
